// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a requester and the sequential binary-to-BCD converter.
// The converter drives the results; the requester drives start and bin_in.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin_in,
        input  busy, done, overflow, bcd_out, blank
    );

    modport slave (
        input  start, bin_in,
        output busy, done, overflow, bcd_out, blank
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one operand bit per clock, packed BCD result
// plus a leading-zero blank mask for the seven-segment display stage.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CAT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0]       LIMIT      = 64'(10 ** DIGITS);
    localparam logic [BIN_W-1:0]  SAT_VAL    = BIN_W'(LIMIT - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BIN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RST  = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Add 3 to every nibble >= 5; nibbles are corrected independently, never carrying.
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Digit i (i >= 1) is blanked when it and every higher digit are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] m;
        logic              zero_run;
        m        = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (bcd[4*i +: 4] == 4'd0);
            m[i]     = zero_run;
        end
        return m;
    endfunction

    state_t             state_r;
    logic [BCD_W-1:0]   acc_r;
    logic [BIN_W-1:0]   op_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sat_r;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [DIGITS-1:0]  blank_r;

    logic               sat_s;
    logic [CAT_W-1:0]   cat_s;
    logic [BCD_W-1:0]   acc_next_s;
    logic [BIN_W-1:0]   op_next_s;

    // Next-iteration datapath and operand range check.
    always_comb begin
        sat_s      = 1'b0;
        cat_s      = '0;
        sat_s      = (64'(bus.bin_in) >= LIMIT);
        cat_s      = {add3_nibbles(acc_r), op_r} << 1;
        acc_next_s = cat_s[CAT_W-1 -: BCD_W];
        op_next_s  = cat_s[BIN_W-1:0];
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= '0;
            op_r    <= '0;
            cnt_r   <= '0;
            sat_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            bcd_r   <= '0;
            blank_r <= BLANK_RST;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_r    <= sat_s ? SAT_VAL : bus.bin_in;
                        sat_r   <= sat_s;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc_r <= acc_next_s;
                    op_r  <= op_next_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        bcd_r   <= acc_next_s;
                        blank_r <= blank_mask(acc_next_s);
                        ovf_r   <= sat_r;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.bcd_out  = bcd_r;
    assign bus.blank    = blank_r;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a table of operands with hand-computed BCD results,
// followed by hand-written sequences for ignored starts, back-to-back runs and mid-run reset.
module tb_bin2bcd_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one start pulse and follow the run to its done pulse (bounded).
    task automatic run_conv(input logic [13:0] v, output int lat, output int busy_cnt);
        bus.bin_in = v;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        lat        = 0;
        busy_cnt   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dones;
        int last_k;
        int bad_busy;
        int bad_gap;
        logic [15:0] seen_bcd;

        n_vec = 0;
        n_bad = 0;
        bus.start  = 1'b0;
        bus.bin_in = 14'd0;
        rst_n      = 1'b0;

        vecs[0]  = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
        vecs[1]  = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
        vecs[2]  = '{14'd12000, 16'h9999, 1'b1, 4'b0000};
        vecs[3]  = '{14'd7,     16'h0007, 1'b0, 4'b1110};
        vecs[4]  = '{14'd0,     16'h0000, 1'b0, 4'b1110};
        vecs[5]  = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
        vecs[6]  = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
        vecs[7]  = '{14'd10,    16'h0010, 1'b0, 4'b1100};
        vecs[8]  = '{14'd305,   16'h0305, 1'b0, 4'b1000};
        vecs[9]  = '{14'd100,   16'h0100, 1'b0, 4'b1000};
        vecs[10] = '{14'd8765,  16'h8765, 1'b0, 4'b0000};

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_bcd",   32'(bus.bcd_out),  32'h0000);
        check("reset_busy",  32'(bus.busy),     32'd0);
        check("reset_done",  32'(bus.done),     32'd0);
        check("reset_ovf",   32'(bus.overflow), 32'd0);
        check("reset_blank", 32'(bus.blank),    32'b1110);

        for (int i = 0; i < 11; i++) begin
            run_conv(vecs[i].bin, lat, bcnt);
            check("latency",    32'(lat),          32'd14);
            check("busy_cycles", 32'(bcnt),        32'd14);
            check("bcd",        32'(bus.bcd_out),  32'(vecs[i].bcd));
            check("overflow",   32'(bus.overflow), 32'(vecs[i].ovf));
            check("blank",      32'(bus.blank),    32'(vecs[i].blank));
            check("busy_at_done", 32'(bus.busy),   32'd0);
            @(posedge clk); #1;
            check("done_one_cycle", 32'(bus.done), 32'd0);
            check("bcd_held",   32'(bus.bcd_out),  32'(vecs[i].bcd));
        end

        // Starts during a conversion are ignored and not queued.
        bus.bin_in = 14'd56;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.bin_in = 14'd999;
        dones  = 0;
        last_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                last_k = k;
            end
            bus.start = (k == 3 || k == 10);
        end
        bus.start = 1'b0;
        check("ignore_dones", 32'(dones),       32'd1);
        check("ignore_lat",   32'(last_k),      32'd14);
        check("ignore_bcd",   32'(bus.bcd_out), 32'h0056);

        // Start held high: one result every 15 cycles, busy low only in done cycles.
        bus.bin_in = 14'd305;
        bus.start  = 1'b1;
        dones    = 0;
        last_k   = -1;
        bad_busy = 0;
        bad_gap  = 0;
        seen_bcd = 16'h0305;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (bus.busy === bus.done) bad_busy++;
            if (bus.done) begin
                dones++;
                if (bus.bcd_out !== 16'h0305) seen_bcd = bus.bcd_out;
                if (last_k >= 0 && (k - last_k) != 15) bad_gap++;
                if (last_k < 0 && k != 14) bad_gap++;
                last_k = k;
            end
        end
        bus.start = 1'b0;
        check("b2b_dones",    32'(dones),    32'd3);
        check("b2b_gap_errs", 32'(bad_gap),  32'd0);
        check("b2b_busy_errs", 32'(bad_busy), 32'd0);
        check("b2b_bcd",      32'(seen_bcd), 32'h0305);

        // Reset in the middle of a conversion aborts it.
        @(posedge clk); #1;
        bus.bin_in = 14'd4321;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        dones = 0;
        for (int k = 1; k < 7; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_bcd",   32'(bus.bcd_out),  32'h0000);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_ovf",   32'(bus.overflow), 32'd0);
        check("rst_blank", 32'(bus.blank),    32'b1110);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        run_conv(14'd10, lat, bcnt);
        check("post_rst_lat",   32'(lat),         32'd14);
        check("post_rst_bcd",   32'(bus.bcd_out), 32'h0010);
        check("post_rst_blank", 32'(bus.blank),   32'b1100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
